// File: rtl/reg8_serializer.sv
// Parallel-in, serial-out transmit register. A word is accepted through a
// valid/ready handshake and then shifted out one bit per enabled clock, with
// frame_start flagging the first bit and done flagging the last bit.
module reg8_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] D,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             enable,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    count_q, count_d;

    logic is_last;
    logic take;
    logic cur_bit;

    // Handshake and next-state: load wins over shifting, shifting only on enable.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path leaves
        // it unassigned; a missing default here would infer a latch.
        state_d    = state_q;
        shreg_d    = shreg_q;
        count_d    = count_q;
        is_last    = (count_q == LAST_CNT);
        // Ready while idle, or on the final enabled bit so the next word can
        // follow with no gap. Held low during reset since no load can happen.
        load_ready = reset && ((state_q == IDLE) || (is_last && enable));
        take       = load_valid && load_ready;

        if (take) begin
            // The load edge ignores enable while idle; from SHIFT it only
            // happens on the final enabled edge (gated by load_ready above).
            state_d = SHIFT;
            shreg_d = D;
            count_d = '0;
        end else if (state_q == SHIFT && enable) begin
            if (is_last) begin
                state_d = IDLE;
                count_d = '0;
            end else begin
                shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                    : {1'b0, shreg_q[WIDTH-1:1]};
                count_d = count_q + CW'(1);
            end
        end
    end

    // Serial outputs decode directly from registered state, so a stalled bit
    // stays perfectly stable.
    always_comb begin
        cur_bit     = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
        ser_valid   = (state_q == SHIFT);
        ser_out     = ser_valid && cur_bit;
        frame_start = ser_valid && (count_q == '0);
        done        = ser_valid && is_last;
    end

    // State, shift register and bit counter with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (!reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_reg8_serializer.sv
// Self-checking bench for reg8_serializer: a cycle table for the default
// MSB-first 8-bit instance, plus hand-written sequences for an LSB-first
// instance (reset mid-word) and a WIDTH=2 instance (back-to-back frames).
module tb_reg8_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // MSB-first, WIDTH=8
    logic       m_reset, m_lv, m_en, m_lr, m_so, m_sv, m_fs, m_dn;
    logic [7:0] m_d;
    // LSB-first, WIDTH=8
    logic       l_reset, l_lv, l_en, l_lr, l_so, l_sv, l_fs, l_dn;
    logic [7:0] l_d;
    // MSB-first, WIDTH=2
    logic       w_reset, w_lv, w_en, w_lr, w_so, w_sv, w_fs, w_dn;
    logic [1:0] w_d;

    reg8_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .reset(m_reset), .D(m_d), .load_valid(m_lv), .load_ready(m_lr),
        .enable(m_en), .ser_out(m_so), .ser_valid(m_sv), .frame_start(m_fs), .done(m_dn)
    );

    reg8_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset(l_reset), .D(l_d), .load_valid(l_lv), .load_ready(l_lr),
        .enable(l_en), .ser_out(l_so), .ser_valid(l_sv), .frame_start(l_fs), .done(l_dn)
    );

    reg8_serializer #(.WIDTH(2), .MSB_FIRST(1'b1)) u_w2 (
        .clk(clk), .reset(w_reset), .D(w_d), .load_valid(w_lv), .load_ready(w_lr),
        .enable(w_en), .ser_out(w_so), .ser_valid(w_sv), .frame_start(w_fs), .done(w_dn)
    );

    // One cycle of stimulus and the outputs expected during that cycle
    // (before the next rising edge). exp = {ser_out, ser_valid, frame_start, done, load_ready}.
    typedef struct {
        logic       rst;
        logic [7:0] d;
        logic       lv;
        logic       en;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual={so,sv,fs,dn,lr}=%b required=%b", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic [7:0] d, input logic lv, input logic en,
                       input logic so, input logic sv, input logic fs, input logic dn,
                       input logic lr);
        vecs.push_back('{rst: rst, d: d, lv: lv, en: en, exp: {so, sv, fs, dn, lr}});
    endtask

    // Drive the LSB instance for one cycle and check its outputs.
    task automatic lsb_cycle(input string name, input logic rst, input logic [7:0] d,
                             input logic lv, input logic [4:0] exp);
        @(negedge clk);
        l_reset = rst; l_d = d; l_lv = lv; l_en = 1'b1;
        #1;
        check(name, {l_so, l_sv, l_fs, l_dn, l_lr}, exp);
    endtask

    // Drive the WIDTH=2 instance for one cycle and check its outputs.
    task automatic w2_cycle(input string name, input logic [1:0] d, input logic lv,
                            input logic [4:0] exp);
        @(negedge clk);
        w_reset = 1'b1; w_d = d; w_lv = lv; w_en = 1'b1;
        #1;
        check(name, {w_so, w_sv, w_fs, w_dn, w_lr}, exp);
    endtask

    initial begin
        // Hold every instance in reset through the first edge.
        m_reset = 1'b0; m_d = 8'hFF; m_lv = 1'b1; m_en = 1'b1;
        l_reset = 1'b0; l_d = 8'h00; l_lv = 1'b0; l_en = 1'b1;
        w_reset = 1'b0; w_d = 2'b00; w_lv = 1'b0; w_en = 1'b1;

        //   rst  D      lv  en   so sv fs dn lr
        // Reset held with load_valid=1, D=FF: everything quiet.
        add(0, 8'hFF, 1, 1,  0, 0, 0, 0, 0);
        add(0, 8'hFF, 1, 1,  0, 0, 0, 0, 0);
        // Released: idle and ready; load AA on this edge.
        add(1, 8'hAA, 1, 1,  0, 0, 0, 0, 1);
        // AA = 1010_1010, MSB first.
        add(1, 8'h00, 0, 1,  1, 1, 1, 0, 0);
        add(1, 8'h00, 0, 1,  0, 1, 0, 0, 0);
        add(1, 8'h00, 0, 1,  1, 1, 0, 0, 0);
        add(1, 8'h00, 0, 1,  0, 1, 0, 0, 0);
        add(1, 8'h00, 0, 1,  1, 1, 0, 0, 0);
        add(1, 8'h00, 0, 1,  0, 1, 0, 0, 0);
        add(1, 8'h00, 0, 1,  1, 1, 0, 0, 0);
        add(1, 8'h00, 0, 1,  0, 1, 0, 1, 1);
        // Back to idle.
        add(1, 8'h00, 0, 1,  0, 0, 0, 0, 1);
        // Load CC with enable low: the load itself ignores enable.
        add(1, 8'hCC, 1, 0,  0, 0, 0, 0, 1);
        // CC = 1100_1100; bit 3 (0) stalls for three extra cycles.
        add(1, 8'h00, 0, 1,  1, 1, 1, 0, 0);
        add(1, 8'h00, 0, 1,  1, 1, 0, 0, 0);
        add(1, 8'h00, 0, 0,  0, 1, 0, 0, 0);
        add(1, 8'h00, 0, 0,  0, 1, 0, 0, 0);
        add(1, 8'h00, 0, 0,  0, 1, 0, 0, 0);
        add(1, 8'h00, 0, 1,  0, 1, 0, 0, 0);
        add(1, 8'h00, 0, 1,  0, 1, 0, 0, 0);
        add(1, 8'h00, 0, 1,  1, 1, 0, 0, 0);
        add(1, 8'h00, 0, 1,  1, 1, 0, 0, 0);
        add(1, 8'h00, 0, 1,  0, 1, 0, 0, 0);
        // Last bit stalled: done holds, not ready while enable=0; a pending load is ignored.
        add(1, 8'h55, 1, 0,  0, 1, 0, 1, 0);
        // Last bit enabled with load_valid: back-to-back load of CC.
        add(1, 8'hCC, 1, 1,  0, 1, 0, 1, 1);
        // CC streams while F0 is offered and refused until the last bit.
        add(1, 8'hF0, 1, 1,  1, 1, 1, 0, 0);
        add(1, 8'hF0, 1, 1,  1, 1, 0, 0, 0);
        add(1, 8'hF0, 1, 1,  0, 1, 0, 0, 0);
        add(1, 8'hF0, 1, 1,  0, 1, 0, 0, 0);
        add(1, 8'hF0, 1, 1,  1, 1, 0, 0, 0);
        add(1, 8'hF0, 1, 1,  1, 1, 0, 0, 0);
        add(1, 8'hF0, 1, 1,  0, 1, 0, 0, 0);
        add(1, 8'hF0, 1, 1,  0, 1, 0, 1, 1);
        // F0 = 1111_0000 follows with no gap; D changes to 00 mid-word.
        add(1, 8'h00, 0, 1,  1, 1, 1, 0, 0);
        add(1, 8'h00, 0, 1,  1, 1, 0, 0, 0);
        add(1, 8'h00, 0, 1,  1, 1, 0, 0, 0);
        add(1, 8'h00, 0, 1,  1, 1, 0, 0, 0);
        add(1, 8'h00, 0, 1,  0, 1, 0, 0, 0);
        add(1, 8'h00, 0, 1,  0, 1, 0, 0, 0);
        add(1, 8'h00, 0, 1,  0, 1, 0, 0, 0);
        add(1, 8'h00, 0, 1,  0, 1, 0, 1, 1);
        add(1, 8'h00, 0, 1,  0, 0, 0, 0, 1);

        @(posedge clk);
        foreach (vecs[i]) begin
            @(negedge clk);
            m_reset = vecs[i].rst; m_d = vecs[i].d; m_lv = vecs[i].lv; m_en = vecs[i].en;
            #1;
            check($sformatf("msb_vec%0d", i), {m_so, m_sv, m_fs, m_dn, m_lr}, vecs[i].exp);
        end
        @(negedge clk);
        m_lv = 1'b0;

        // LSB-first: load 01 -> 1,0,0,0, reset after bit 4, then 80 -> 0x7 then 1.
        lsb_cycle("lsb_idle",     1'b1, 8'h01, 1'b1, 5'b00001);
        lsb_cycle("lsb_b1",       1'b1, 8'hFF, 1'b0, 5'b11100);
        lsb_cycle("lsb_b2",       1'b1, 8'hFF, 1'b0, 5'b01000);
        lsb_cycle("lsb_b3",       1'b1, 8'hFF, 1'b0, 5'b01000);
        lsb_cycle("lsb_b4_rst",   1'b0, 8'hFF, 1'b1, 5'b01000);
        lsb_cycle("lsb_post_rst", 1'b1, 8'h80, 1'b1, 5'b00001);
        for (int i = 0; i < 7; i++)
            lsb_cycle($sformatf("lsb80_b%0d", i + 1), 1'b1, 8'h00, 1'b0,
                      (i == 0) ? 5'b01100 : 5'b01000);
        lsb_cycle("lsb80_b8",     1'b1, 8'h00, 1'b0, 5'b11011);
        lsb_cycle("lsb80_idle",   1'b1, 8'h00, 1'b0, 5'b00001);

        // WIDTH=2: 01 then 10 back-to-back; frame_start and done on alternating cycles.
        w2_cycle("w2_idle",  2'b01, 1'b1, 5'b00001);
        w2_cycle("w2_a_b1",  2'b10, 1'b1, 5'b01100);
        w2_cycle("w2_a_b2",  2'b10, 1'b1, 5'b11011);
        w2_cycle("w2_b_b1",  2'b00, 1'b0, 5'b11100);
        w2_cycle("w2_b_b2",  2'b00, 1'b0, 5'b01011);
        w2_cycle("w2_done",  2'b00, 1'b0, 5'b00001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
